gate_truth_table_checker: RTL and testbench
===========================================

Name: gate_truth_table_checker

Overview:
- Self-contained stimulus-and-check stage wrapped around the 2-input NAND/NOR universal-gate block.
- On `start`, drives the gate inputs `a`,`b` through the full 2-bit truth table (00, 01, 10, 11), holding each vector for DWELL cycles.
- Samples the `g_nand`/`g_nor` results, compares them against the expected values and reports a mismatch count, the first failing vector and pass/fail.
- Replaces open-loop `$monitor` benches with a synthesizable, self-checking harness.

Parameters:
- DWELL, 4: clock cycles each input vector is held. Legal range 1..255.
- ERR_W, 3: width of the mismatch counter. Legal range 1..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- a  output  1  gate input a, registered
- b  output  1  gate input b, registered
- g_nand  input  1  NAND result from the gate block
- g_nor  input  1  NOR result from the gate block
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse at end of sweep
- pass  output  1  1 when the last sweep had zero mismatches
- err_cnt  output  ERR_W  mismatching vectors in the last sweep, saturating
- fail_valid  output  1  at least one mismatch seen in the last sweep
- fail_vec  output  2  {a,b} of the first mismatching vector

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; a=b=0; busy=0; done=0; pass=0; err_cnt=0; fail_valid=0; fail_vec=00.
- State IDLE:
  - a=b=0, busy=0.
  - `start`=1 at an edge moves to RUN.
  - On that same edge: vec=00, dwell_cnt=0, err_cnt=0, fail_valid=0, fail_vec=00, pass=0.
- State RUN:
  - busy=1, {a,b}=vec, all registered.
  - dwell_cnt increments each cycle, 0..DWELL-1.
  - Sample edge: dwell_cnt==DWELL-1.
  - Expected values: exp_nand=~(a&b), exp_nor=~(a|b), computed from the registered a,b.
  - Mismatch: g_nand!=exp_nand OR g_nor!=exp_nor. A vector counts as one mismatch even if both outputs are wrong.
- On a mismatch:
  - err_cnt increments, saturating at 2^ERR_W-1.
  - If fail_valid==0: fail_vec={a,b} and fail_valid=1. Later mismatches never overwrite fail_vec.
- Vector advance:
  - On a sample edge with vec!=11: vec increments and dwell_cnt resets to 0.
  - On the sample edge of vec=11: move to DONE.
- State DONE, exactly one cycle:
  - done=1, busy=0, a=b=0.
  - pass=(err_cnt==0), including any mismatch from the final sample.
  - Next state is IDLE.
- Result hold: pass, err_cnt, fail_valid and fail_vec hold until the next accepted start or rst.
- Latency:
  - busy rises the cycle after the start edge.
  - A sweep occupies 4*DWELL cycles in RUN.
  - done is high in cycle 4*DWELL+1 after the start edge.
- `start` is ignored in RUN and DONE; it is not queued.
- `rst` asserted mid-sweep overrides everything: return to IDLE with reset values on the next edge. No done pulse is produced.
- DWELL=1: each vector is held one cycle and sampled on that same cycle's edge.
- The gate block is treated as combinational; its outputs must be settled within one cycle of a/b changing.

Optional Feature:
- Macro: GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep. The next state is DONE; remaining vectors are not driven; err_cnt=1, pass=0.
- Undefined: all four vectors are always swept and every mismatch is counted.

Test Plan:
- Correct gate model, DWELL=4, pulse `start` → {a,b} steps 00,01,10,11 for 4 cycles each; done pulses once in cycle 17; pass=1, err_cnt=0, fail_valid=0.
- g_nand stuck at 1 → only vector 11 fails; err_cnt=1, fail_vec=11, pass=0.
- g_nand and g_nor wired swapped → vectors 01 and 10 fail; err_cnt=2, fail_vec=01. With GATE_CHK_STOP_ON_FAIL_EN defined: done follows the vector-01 sample edge, err_cnt=1.
- Both outputs inverted, ERR_W=2 → all four vectors fail; err_cnt saturates at 3, fail_vec=00.
- Pulse `start` again at cycle 6 of a sweep → ignored; sweep timing unchanged and exactly one done pulse.
- Assert `rst` during vector 10 → next edge gives busy=0, a=b=0, err_cnt=0, no done. A fresh start then completes with pass=1.

Source files
------------

// File: rtl/gate_truth_table_checker_if.sv
// Handshake and gate-side bus between the truth-table checker and its environment.
// master drives start and the gate results; slave is the checker.
interface gate_truth_table_checker_if #(
    parameter int ERR_W = 3
);
    logic             start;
    logic             a;
    logic             b;
    logic             g_nand;
    logic             g_nor;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [1:0]       fail_vec;

    modport master (
        output start, g_nand, g_nor,
        input  a, b, busy, done, pass, err_cnt, fail_valid, fail_vec
    );

    modport slave (
        input  start, g_nand, g_nor,
        output a, b, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps a 2-input NAND/NOR block through 00,01,10,11 and scores its outputs.
// Define GATE_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_truth_table_checker #(
    parameter int DWELL = 4,
    parameter int ERR_W = 3
) (
    input logic                          clk,
    input logic                          rst,
    gate_truth_table_checker_if.slave    bus
);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       vec, vec_n;
    logic [7:0]       dwell_cnt, dwell_n;
    logic             a_q, a_n, b_q, b_n;
    logic             busy_q, busy_n, done_q, done_n, pass_q, pass_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic             fv_q, fv_n;
    logic [1:0]       fvec_q, fvec_n;
    logic             mismatch;

    // Expectation uses the registered vector actually presented to the gate.
    assign mismatch = (bus.g_nand != ~(a_q & b_q)) || (bus.g_nor != ~(a_q | b_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= 2'b00;
            dwell_cnt <= 8'd0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fv_q      <= 1'b0;
            fvec_q    <= 2'b00;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            dwell_cnt <= dwell_n;
            a_q       <= a_n;
            b_q       <= b_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            pass_q    <= pass_n;
            err_q     <= err_n;
            fv_q      <= fv_n;
            fvec_q    <= fvec_n;
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        dwell_n = dwell_cnt;
        a_n     = a_q;
        b_n     = b_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        pass_n  = pass_q;
        err_n   = err_q;
        fv_n    = fv_q;
        fvec_n  = fvec_q;
        case (state)
            IDLE: begin
                a_n    = 1'b0;
                b_n    = 1'b0;
                busy_n = 1'b0;
                if (bus.start) begin
                    state_n = RUN;
                    vec_n   = 2'b00;
                    dwell_n = 8'd0;
                    err_n   = '0;
                    fv_n    = 1'b0;
                    fvec_n  = 2'b00;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            RUN: begin
                busy_n  = 1'b1;
                dwell_n = dwell_cnt + 8'd1;
                if (dwell_cnt == DWELL_LAST) begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX)
                            err_n = err_q + ERR_W'(1);
                        if (!fv_q) begin
                            fv_n   = 1'b1;
                            fvec_n = {a_q, b_q};
                        end
                    end
                    if (vec == 2'b11 || (STOP_ON_FAIL && mismatch)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        pass_n  = (err_n == '0);
                    end else begin
                        vec_n      = vec + 2'b01;
                        dwell_n    = 8'd0;
                        {a_n, b_n} = vec + 2'b01;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                a_n     = 1'b0;
                b_n     = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a fault-injectable gate model plus a sweep-level reference.
module tb_gate_truth_table_checker;
    localparam int DWELL   = 4;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_truth_table_checker_if #(.ERR_W(ERR_W)) bus ();

    // Per-vector fault table: bit1 flips the NAND result, bit0 flips the NOR result.
    logic [3:0][1:0] ftab = '0;
    assign bus.g_nand = ~(bus.a & bus.b) ^ ftab[{bus.a, bus.b}][1];
    assign bus.g_nor  = ~(bus.a | bus.b) ^ ftab[{bus.a, bus.b}][0];

    gate_truth_table_checker #(.DWELL(DWELL), .ERR_W(ERR_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sweep-level reference: outcome computed from the fault table when a start is accepted.
    int       t = 0;
    int       len = 4 * DWELL;
    int       m_err = 0, f_err = 0;
    bit       m_fv = 0, m_pass = 0, f_fv = 0, f_pass = 0;
    bit [1:0] m_fvec = 0, f_fvec = 0;

    task automatic plan();
        int nf;
        int first;
        nf = 0;
        first = -1;
        for (int v = 0; v < 4; v++)
            if (ftab[v] != 2'b00) begin
                nf++;
                if (first < 0) first = v;
            end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        len   = ((first >= 0) ? first + 1 : 4) * DWELL;
        f_err = (nf > 0) ? 1 : 0;
`else
        len   = 4 * DWELL;
        f_err = (nf > ERR_MAX) ? ERR_MAX : nf;
`endif
        f_pass = (nf == 0);
        f_fv   = (nf != 0);
        f_fvec = (first >= 0) ? 2'(first) : 2'b00;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            t = 0; m_err = 0; m_fv = 0; m_pass = 0; m_fvec = 0;
        end else if (t == 0) begin
            if (bus.start) begin
                plan();
                t = 1; m_err = 0; m_fv = 0; m_pass = 0; m_fvec = 0;
            end
        end else begin
            t++;
            if (t == len + 1) begin
                m_err = f_err; m_fv = f_fv; m_pass = f_pass; m_fvec = f_fvec;
            end else if (t > len + 1) begin
                t = 0;
            end
        end
    end

    bit       e_busy, e_done;
    bit [1:0] e_ab;
    always @(negedge clk) begin
        e_busy = (t >= 1) && (t <= len);
        e_done = (t == len + 1);
        e_ab   = e_busy ? 2'((t - 1) / DWELL) : 2'b00;
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("ab", {bus.a, bus.b}, e_ab);
        if (!e_busy) begin
            chk("err_cnt", bus.err_cnt, m_err);
            chk("pass", bus.pass, m_pass);
            chk("fail_valid", bus.fail_valid, m_fv);
            chk("fail_vec", bus.fail_vec, m_fvec);
        end
    end

    // Pulses start, optionally re-pulses it at cycle restart_at, returns the cycle done was seen.
    task automatic sweep(input logic [3:0][1:0] tab, input int restart_at, output int done_at);
        ftab = tab;
        done_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (bus.done) begin
                done_at = k;
                break;
            end
        end
        bus.start = 1'b0;
        if (done_at < 0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    int d;
    initial begin
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_cnt, 0);
        chk("rst_pass", bus.pass, 0);
        rst = 1'b0;
        @(negedge clk);

        // Healthy gate
        sweep(8'h00, -1, d);
        chk("ok_lat", d, 17);
        chk("ok_pass", bus.pass, 1);
        chk("ok_err", bus.err_cnt, 0);
        chk("ok_fv", bus.fail_valid, 0);

        // NAND stuck at 1: only vector 11 differs
        sweep(8'b10_00_00_00, -1, d);
        chk("stuck_lat", d, 17);
        chk("stuck_err", bus.err_cnt, 1);
        chk("stuck_fvec", bus.fail_vec, 2'b11);
        chk("stuck_pass", bus.pass, 0);

        // NAND/NOR swapped: vectors 01 and 10 differ on both outputs
        sweep(8'b00_11_11_00, -1, d);
        chk("swap_fvec", bus.fail_vec, 2'b01);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        chk("swap_lat", d, 9);
        chk("swap_err", bus.err_cnt, 1);
`else
        chk("swap_lat", d, 17);
        chk("swap_err", bus.err_cnt, 2);
`endif

        // Both outputs inverted: every vector fails, counter saturates
        sweep(8'hFF, -1, d);
        chk("inv_fvec", bus.fail_vec, 2'b00);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        chk("inv_err", bus.err_cnt, 1);
`else
        chk("inv_err", bus.err_cnt, 3);
`endif

        // start re-pulsed mid-sweep is ignored
        sweep(8'h00, 6, d);
        chk("restart_lat", d, 17);
        chk("restart_pass", bus.pass, 1);

        // Reset during vector 10
        ftab = 8'b00_11_11_00;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ab", {bus.a, bus.b}, 0);
        chk("midrst_err", bus.err_cnt, 0);
        chk("midrst_done", bus.done, 0);
        rst = 1'b0;
        sweep(8'h00, -1, d);
        chk("midrst_pass", bus.pass, 1);

        // Random fault tables, gaps and stray starts
        for (int i = 0; i < 30; i++) begin
            logic [3:0][1:0] tab;
            tab = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sweep(tab, $urandom_range(0, 20), d);
            chk("rand_lat", d, len + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
